usrt_tx_fifo: RTL and testbench
===============================

# usrt_tx_fifo

APB-side transmit buffer sitting directly upstream of the USRT serializer. Accepts bytes written by the bus master over the AMBA APB slave port, queues them in a DEPTH-entry FIFO, and presents them to the serializer over a valid/ready handshake. Also exposes status (empty/full/overflow/count) and control (transmit enable, flush) registers to the bus.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..16
- pClk  input  1  bus clock; all logic rising-edge
- pReset  input  1  asynchronous, active-low reset
- pSelect  input  1  APB slave select
- pEnable  input  1  APB access phase
- pWrite  input  1  1 = write, 0 = read
- pAddress  input  33  byte address; only [3:0] decoded
- pWData  input  8  write data
- pRData  output  8  read data, valid when pReady=1 and pWrite=0
- pReady  output  1  access-phase completion
- txData  output  8  byte at FIFO head
- txValid  output  1  head byte available to serializer
- txReady  input  1  serializer accepts txData this cycle

## Operation
- Register map (pAddress[3:0]): 0x0 DATA (W: push byte; R: 0x00), 0x4 STATUS (R only), 0x8 CTRL (R/W). Other offsets: writes ignored, reads 0x00.
- STATUS: bit0 empty, bit1 full, bit2 overflow (sticky), bits[7:3] count (0..DEPTH).
- CTRL: bit0 tx_en (R/W, reset 0); bit1 flush (write-1 self-clearing, reads 0); bit2 ovf_clr (write-1 clears overflow, reads 0).
- APB: zero wait states; pReady = pSelect & pEnable. Register writes commit at the pClk edge ending the access phase. Setup phase (pSelect & !pEnable) has no side effects.
- Push: DATA write in access phase. If not full, byte stored at tail, tail and count increment. If full and no pop in the same cycle, byte dropped, overflow set to 1.
- Pop: txValid & txReady at a pClk edge; head and count advance.
- txValid = tx_en & !empty. txData = head entry (stable while txValid held and no pop). No fall-through: a byte pushed in cycle N is first visible on txValid in cycle N+1.
- Full with simultaneous push and pop: both performed, count unchanged, no overflow.
- Flush: head, tail, count reset to empty; overflow unchanged. Flush with a simultaneous pop: flush wins, count = 0.
- Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
- Reset: pointers and count 0, tx_en 0, overflow 0; outputs pRData=0x00, pReady=0, txValid=0, txData=0x00.

## Timing
- Push-to-txValid latency: 1 cycle (tx_en=1).
- STATUS read reflects state before the edge ending the read access.
- pRData combinational from address in access phase, 0x00 otherwise.
- Reset assertion mid-transfer: immediate clear, queued bytes lost; no pop reported.
- tx_en cleared while txValid=1: txValid drops next cycle; head byte retained.

## Structure
- Shared package usrt_pkg: register offsets (DATA/STATUS/CTRL), STATUS and CTRL bit positions, default DEPTH.
- One sub-module: usrt_sync_fifo (storage, pointers, count, full/empty, push/pop/flush) in pClk domain; APB decode and register logic in the top block.

## Test plan
- Reset, then read STATUS -> 0x01 (empty, count 0); txValid=0.
- tx_en=1, write 0xA5, 0x3C to DATA, txReady=1 -> txData 0xA5 then 0x3C on consecutive cycles, STATUS returns 0x01.
- txReady=0, write DATA DEPTH+1 times -> STATUS full, count=DEPTH, overflow=1; extra byte absent; CTRL ovf_clr=1 clears bit2 only.
- Full FIFO, txReady=1 and DATA write in the same cycle -> count stays DEPTH, overflow stays 0, order preserved.
- Push 5 bytes, write CTRL=0x03 (flush) with txReady=1 -> STATUS 0x01 next cycle, txValid=0.
- Push 3 bytes, assert pReset low mid-stream -> txValid=0 immediately, STATUS reads 0x01 after release, tx_en reads 0.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT transmit path: register offsets, STATUS/CTRL
// bit positions and the default buffer depth.
package usrt_pkg;

    localparam int DEFAULT_DEPTH = 8;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 3;
    localparam int STAT_CNT_W   = 5;

    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_OVF_CLR = 2;

endpackage

// File: rtl/usrt_sync_fifo.sv
// Single-clock circular FIFO with occupancy count, push/pop/flush and a
// registered (non fall-through) head output.
module usrt_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic              doPush;
    logic              doPop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A pop frees the slot the push lands in, so a full FIFO may still accept.
    assign doPush = push & ~flush & (~full | pop);
    assign doPop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else if (flush) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (doPush) tailPtr <= tailPtr + 1'b1;
            if (doPop)  headPtr <= headPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[tailPtr] <= wrData;
    end

    assign rdData = empty ? '0 : mem[headPtr];

endmodule

// File: rtl/usrt_tx_fifo.sv
// APB-programmable transmit buffer feeding the USRT serializer over a
// valid/ready handshake; holds DATA/STATUS/CTRL registers.
module usrt_tx_fifo
    import usrt_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        pClk,
    input  logic        pReset,
    input  logic        pSelect,
    input  logic        pEnable,
    input  logic        pWrite,
    input  logic [32:0] pAddress,
    input  logic [7:0]  pWData,
    output logic [7:0]  pRData,
    output logic        pReady,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [3:0]       regAddr;
    logic             unusedAddrBits;
    logic             access;
    logic             busWrite;
    logic             busRead;
    logic             push;
    logic             pop;
    logic             flush;
    logic             ctrlWrite;
    logic             full;
    logic             empty;
    logic             txEn;
    logic             overflow;
    logic [CNT_W-1:0] count;
    logic [7:0]       statusByte;
    logic [7:0]       ctrlByte;

    assign regAddr        = pAddress[3:0];
    assign unusedAddrBits = ^pAddress[32:4];

    assign access   = pSelect & pEnable;
    assign pReady   = access;
    assign busWrite = access & pWrite;
    assign busRead  = access & ~pWrite;

    assign push      = busWrite & (regAddr == REG_DATA);
    assign ctrlWrite = busWrite & (regAddr == REG_CTRL);
    assign flush     = ctrlWrite & pWData[CTRL_FLUSH];

    assign txValid = txEn & ~empty;
    assign pop     = txValid & txReady;

    usrt_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) uFifo (
        .clk    (pClk),
        .rstN   (pReset),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .wrData (pWData),
        .rdData (txData),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    // Overflow only when a byte is really dropped: full with no pop freeing a slot.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            txEn     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ctrlWrite) txEn <= pWData[CTRL_TX_EN];
            if (push & full & ~pop)
                overflow <= 1'b1;
            else if (ctrlWrite & pWData[CTRL_OVF_CLR])
                overflow <= 1'b0;
        end
    end

    always_comb begin
        statusByte = '0;
        statusByte[STAT_EMPTY] = empty;
        statusByte[STAT_FULL]  = full;
        statusByte[STAT_OVF]   = overflow;
        statusByte[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(count);
        ctrlByte = '0;
        ctrlByte[CTRL_TX_EN] = txEn;
    end

    always_comb begin
        pRData = '0;
        if (busRead) begin
            case (regAddr)
                REG_STATUS: pRData = statusByte;
                REG_CTRL:   pRData = ctrlByte;
                default:    pRData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_usrt_tx_fifo.sv
// Scoreboard bench for usrt_tx_fifo: directed scenarios plus random APB traffic
// checked every cycle against a queue-based model of the buffer.
module tb_usrt_tx_fifo;

    localparam int DEPTH = 8;

    logic        pClk = 1'b0;
    logic        pReset = 1'b0;
    logic        pSelect = 1'b0;
    logic        pEnable = 1'b0;
    logic        pWrite = 1'b0;
    logic [32:0] pAddress = '0;
    logic [7:0]  pWData = '0;
    logic [7:0]  pRData;
    logic        pReady;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady = 1'b0;

    int  nChecks = 0;
    int  nFails  = 0;
    bit  randReady = 1'b0;

    // Reference model state
    logic [7:0] q[$];
    bit         txEnM = 1'b0;
    bit         ovfM  = 1'b0;

    usrt_tx_fifo #(.DEPTH(DEPTH)) dut (
        .pClk     (pClk),
        .pReset   (pReset),
        .pSelect  (pSelect),
        .pEnable  (pEnable),
        .pWrite   (pWrite),
        .pAddress (pAddress),
        .pWData   (pWData),
        .pRData   (pRData),
        .pReady   (pReady),
        .txData   (txData),
        .txValid  (txValid),
        .txReady  (txReady)
    );

    always #5 pClk = ~pClk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] modelStatus();
        logic [7:0] s;
        s = {5'(q.size()), ovfM, (q.size() == DEPTH), (q.size() == 0)};
        return s;
    endfunction

    // Monitor: compare outputs against the model, then advance the model by the
    // inputs that the coming rising edge will see.
    initial begin
        bit         expValid;
        bit         acc;
        bit         popNow;
        bit         wasFull;
        logic [7:0] expRd;
        logic [3:0] a;
        forever begin
            @(negedge pClk);
            if (!pReset) begin
                q.delete();
                txEnM = 1'b0;
                ovfM  = 1'b0;
                check("rst_txValid", txValid, 0);
                check("rst_txData", txData, 0);
                check("rst_pRData", pRData, 0);
                check("rst_pReady", pReady, 0);
            end else begin
                expValid = txEnM && (q.size() > 0);
                check("txValid", txValid, expValid);
                if (q.size() > 0) check("txData", txData, q[0]);
                acc = pSelect && pEnable;
                a   = pAddress[3:0];
                check("pReady", pReady, acc);
                expRd = 8'h00;
                if (acc && !pWrite) begin
                    if (a == 4'h4) expRd = modelStatus();
                    else if (a == 4'h8) expRd = {7'b0, txEnM};
                end
                check("pRData", pRData, expRd);

                popNow  = expValid && txReady;
                wasFull = (q.size() == DEPTH);
                if (acc && pWrite && a == 4'h8) begin
                    if (pWData[1]) q.delete();
                    else if (popNow) void'(q.pop_front());
                    txEnM = pWData[0];
                    if (pWData[2]) ovfM = 1'b0;
                end else begin
                    if (popNow) void'(q.pop_front());
                    if (acc && pWrite && a == 4'h0) begin
                        if (!wasFull || popNow) q.push_back(pWData);
                        else ovfM = 1'b1;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pClk);
            #1;
            if (randReady) txReady = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle();
        pSelect = 1'b0;
        pEnable = 1'b0;
        pWrite  = 1'b0;
    endtask

    task automatic apbWrite(input logic [3:0] a, input logic [7:0] d);
        pSelect  = 1'b1;
        pEnable  = 1'b0;
        pWrite   = 1'b1;
        pAddress = {29'($urandom), a};
        pWData   = d;
        cyc(1);
        pEnable = 1'b1;
        cyc(1);
        idle();
    endtask

    task automatic apbRead(input logic [3:0] a, output logic [7:0] d);
        pSelect  = 1'b1;
        pEnable  = 1'b0;
        pWrite   = 1'b0;
        pAddress = {29'($urandom), a};
        cyc(1);
        pEnable = 1'b1;
        @(negedge pClk);
        d = pRData;
        cyc(1);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time 0x%0h required below 0x%0h", $time, 200000);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] d1;
        logic [7:0] d2;
        int         sel;

        cyc(3);
        pReset = 1'b1;
        cyc(1);

        // Reset state
        apbRead(4'h4, rd);
        check("reset_status", rd, 8'h01);
        check("reset_txValid", txValid, 0);
        apbRead(4'h8, rd);
        check("reset_ctrl", rd, 8'h00);

        // Two bytes delivered back-to-back once the serializer is ready
        apbWrite(4'h8, 8'h01);
        apbWrite(4'h0, 8'hA5);
        apbWrite(4'h0, 8'h3C);
        txReady = 1'b1;
        @(negedge pClk);
        d1 = txData;
        @(negedge pClk);
        d2 = txData;
        @(posedge pClk);
        #1;
        check("first_byte", d1, 8'hA5);
        check("second_byte", d2, 8'h3C);
        apbRead(4'h4, rd);
        check("drained_status", rd, 8'h01);

        // Fill past capacity, then clear the sticky overflow only
        txReady = 1'b0;
        for (int i = 0; i <= DEPTH; i++) apbWrite(4'h0, 8'(8'h10 + i));
        apbRead(4'h4, rd);
        check("overflow_status", rd, 8'(8'h06 | (DEPTH << 3)));
        apbWrite(4'h8, 8'h05);
        apbRead(4'h4, rd);
        check("ovf_clr_status", rd, 8'(8'h02 | (DEPTH << 3)));
        apbRead(4'h8, rd);
        check("ctrl_after_clr", rd, 8'h01);

        // Full FIFO: push and pop on the same edge
        pSelect  = 1'b1;
        pEnable  = 1'b0;
        pWrite   = 1'b1;
        pAddress = 33'h0;
        pWData   = 8'h99;
        cyc(1);
        pEnable = 1'b1;
        txReady = 1'b1;
        cyc(1);
        idle();
        txReady = 1'b0;
        apbRead(4'h4, rd);
        check("full_push_pop_status", rd, 8'(8'h02 | (DEPTH << 3)));
        txReady = 1'b1;
        cyc(DEPTH + 2);
        txReady = 1'b0;
        apbRead(4'h4, rd);
        check("full_drain_status", rd, 8'h01);

        // Flush with a concurrent pop
        for (int i = 0; i < 5; i++) apbWrite(4'h0, 8'(8'h50 + i));
        txReady = 1'b1;
        apbWrite(4'h8, 8'h03);
        @(negedge pClk);
        check("flush_txValid", txValid, 0);
        cyc(1);
        apbRead(4'h4, rd);
        check("flush_status", rd, 8'h01);
        txReady = 1'b0;

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) apbWrite(4'h0, 8'(8'h70 + i));
        @(posedge pClk);
        #3;
        pReset = 1'b0;
        #1;
        check("async_rst_txValid", txValid, 0);
        cyc(2);
        pReset = 1'b1;
        cyc(1);
        apbRead(4'h4, rd);
        check("post_rst_status", rd, 8'h01);
        apbRead(4'h8, rd);
        check("post_rst_ctrl", rd, 8'h00);

        // Random traffic
        apbWrite(4'h8, 8'h01);
        randReady = 1'b1;
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 50) apbWrite(4'h0, 8'($urandom));
            else if (sel < 60)
                apbWrite(4'h8, {5'($urandom), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                                ($urandom_range(0, 3) != 0)});
            else if (sel < 80) apbRead(4'h4, rd);
            else if (sel < 88) apbRead(4'($urandom), rd);
            else if (sel < 94) apbWrite(4'($urandom_range(1, 7)), 8'($urandom));
            else cyc($urandom_range(1, 3));
        end
        randReady = 1'b0;
        txReady   = 1'b1;
        apbWrite(4'h8, 8'h05);
        cyc(DEPTH + 2);
        apbRead(4'h4, rd);
        check("final_status", rd, 8'h01);

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
